// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the CPU datapath.
// The master modport is the controller; the slave modport is the datapath side.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             ir_we;
  logic             mem_re;
  logic             mem_we;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic             reg_we;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             retire;
  logic             trap;
  logic [2:0]       state;
  logic [CNT_W-1:0] inst_count;

  modport master (
    input  op, funct, zero, mem_ready,
    output pc_we, pc_src, ir_we, mem_re, mem_we, alu_src_a, alu_src_b, alu_op,
           reg_we, reg_dst, mem_to_reg, retire, trap, state, inst_count
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_we, pc_src, ir_we, mem_re, mem_we, alu_src_a, alu_src_b, alu_op,
           reg_we, reg_dst, mem_to_reg, retire, trap, state, inst_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset multi-cycle datapath.
// Control outputs are decoded combinationally from state and IR fields.
module multicycle_ctrl #(
  parameter int unsigned CNT_W           = 32,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] inst_q;

  function automatic logic is_legal(input logic [5:0] o, input logic [5:0] f);
    case (o)
      OP_R:                                 is_legal = (f == FN_ADD) || (f == FN_SUB) ||
                                                       (f == FN_AND) || (f == FN_OR)  ||
                                                       (f == FN_SLT);
      OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: is_legal = 1'b1;
      default:                              is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_alu = ALU_AND;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_nxt;
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          inst_q <= '0;
    else if (bus.retire) inst_q <= inst_q + CNT_W'(1);
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt      = state_q;
    bus.pc_we      = 1'b0;
    bus.pc_src     = 2'b00;
    bus.ir_we      = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = ALU_AND;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.retire     = 1'b0;
    bus.trap       = 1'b0;

    case (state_q)
      FETCH: begin
        bus.mem_re    = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = ALU_ADD;
        if (bus.mem_ready) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut while decoding.
        bus.alu_src_b = 2'b11;
        bus.alu_op    = ALU_ADD;
        if (bus.op == OP_J) begin
          bus.pc_we  = 1'b1;
          bus.pc_src = 2'b10;
          bus.retire = 1'b1;
          state_nxt  = FETCH;
        end else if (is_legal(bus.op, bus.funct)) begin
          state_nxt = EXEC;
        end else if (TRAP_ON_ILLEGAL) begin
          state_nxt = TRAP;
        end else begin
          bus.retire = 1'b1;
          state_nxt  = FETCH;
        end
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        case (bus.op)
          OP_R: begin
            bus.alu_op = funct_alu(bus.funct);
            state_nxt  = WB;
          end
          OP_LW, OP_SW: begin
            bus.alu_src_b = 2'b10;
            bus.alu_op    = ALU_ADD;
            state_nxt     = MEM;
          end
          OP_ADDI: begin
            bus.alu_src_b = 2'b10;
            bus.alu_op    = ALU_ADD;
            state_nxt     = WB;
          end
          OP_BEQ: begin
            bus.alu_op = ALU_SUB;
            bus.pc_src = 2'b01;
            bus.pc_we  = bus.zero;
            bus.retire = 1'b1;
            state_nxt  = FETCH;
          end
          default: state_nxt = FETCH;
        endcase
      end
      MEM: begin
        if (bus.op == OP_LW) begin
          bus.mem_re = 1'b1;
          if (bus.mem_ready) state_nxt = WB;
        end else begin
          bus.mem_we = 1'b1;
          if (bus.mem_ready) begin
            bus.retire = 1'b1;
            state_nxt  = FETCH;
          end
        end
      end
      WB: begin
        bus.reg_we     = 1'b1;
        bus.retire     = 1'b1;
        bus.reg_dst    = (bus.op == OP_R);
        bus.mem_to_reg = (bus.op == OP_LW);
        state_nxt      = FETCH;
      end
      TRAP: begin
        bus.trap = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase

    // Reset kills every side effect immediately, not at the next edge.
    if (!reset) begin
      bus.pc_we  = 1'b0;
      bus.ir_we  = 1'b0;
      bus.mem_re = 1'b0;
      bus.mem_we = 1'b0;
      bus.reg_we = 1'b0;
      bus.retire = 1'b0;
      bus.trap   = 1'b0;
    end
  end

  assign bus.state      = 3'(state_q);
  assign bus.inst_count = inst_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors checked against hand-built expectations.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(4)) bus ();
  multicycle_ctrl_if #(.CNT_W(4)) bus2 ();

  multicycle_ctrl #(.CNT_W(4), .TRAP_ON_ILLEGAL(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus));
  multicycle_ctrl #(.CNT_W(4), .TRAP_ON_ILLEGAL(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus2.op        = bus.op;
  assign bus2.funct     = bus.funct;
  assign bus2.zero      = bus.zero;
  assign bus2.mem_ready = bus.mem_ready;

  int ncmp = 0;
  int nerr = 0;

  // Packed order: pc_we pc_src ir_we mem_re mem_we a b alu reg_we reg_dst m2r retire trap state
  function automatic logic [19:0] pk(input logic pw, input logic [1:0] ps, input logic iw,
                                     input logic mr, input logic mw, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] alu, input logic rw,
                                     input logic rd, input logic m2r, input logic rt,
                                     input logic tr, input logic [2:0] st);
    return {pw, ps, iw, mr, mw, sa, sb, alu, rw, rd, m2r, rt, tr, st};
  endfunction

  function automatic logic [19:0] got1();
    return {bus.pc_we, bus.pc_src, bus.ir_we, bus.mem_re, bus.mem_we, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.reg_we, bus.reg_dst, bus.mem_to_reg,
            bus.retire, bus.trap, bus.state};
  endfunction

  function automatic logic [19:0] got2();
    return {bus2.pc_we, bus2.pc_src, bus2.ir_we, bus2.mem_re, bus2.mem_we, bus2.alu_src_a,
            bus2.alu_src_b, bus2.alu_op, bus2.reg_we, bus2.reg_dst, bus2.mem_to_reg,
            bus2.retire, bus2.trap, bus2.state};
  endfunction

  logic [19:0] f_rdy, f_stl, dec, dec_j, dec_ret, ex_i, wb_r, wb_lw, wb_i;
  logic [19:0] mem_lw, mem_sw, mem_sw_rt, trap_v;

  task automatic do_reset();
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.op = 6'b100011; bus.funct = 6'd0; bus.zero = 1'b1; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ncmp++;
    if ({bus.pc_we, bus.ir_we, bus.mem_re, bus.mem_we, bus.reg_we, bus.retire, bus.trap,
         bus.state} !== 10'd0) begin
      nerr++;
      $display("FAIL reset_outputs: got %b want 0", {bus.pc_we, bus.ir_we, bus.mem_re,
               bus.mem_we, bus.reg_we, bus.retire, bus.trap, bus.state});
    end
    ncmp++;
    if (bus.inst_count !== 4'd0) begin
      nerr++; $display("FAIL reset_count: got %0d want 0", bus.inst_count);
    end
    bus.zero = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_add();
    logic [19:0] ex [4];
    ex = '{f_rdy, dec, pk(0,2'b00,0,0,0,1,2'b00,3'b010,0,0,0,0,0,3'd2), wb_r};
    bus.op = 6'b000000; bus.funct = 6'b100000; bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3; ncmp++;
      if (got1() !== ex[i]) begin
        nerr++; $display("FAIL add c%0d: got %h want %h", i, got1(), ex[i]);
      end
      @(posedge clk); #1;
    end
    ncmp++;
    if (bus.inst_count !== 4'd1 || bus.state !== 3'd0) begin
      nerr++; $display("FAIL add_count: got %0d/st%0d want 1/st0", bus.inst_count, bus.state);
    end
  endtask

  task automatic test_lw();
    logic [19:0] ex [8];
    logic        rdy [8];
    ex  = '{f_rdy, dec, ex_i, mem_lw, mem_lw, mem_lw, mem_lw, wb_lw};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.op = 6'b100011; bus.funct = 6'h15;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rdy[i];
      #3; ncmp++;
      if (got1() !== ex[i]) begin
        nerr++; $display("FAIL lw c%0d: got %h want %h", i, got1(), ex[i]);
      end
      @(posedge clk); #1;
    end
    ncmp++;
    if (bus.inst_count !== 4'd2 || bus.state !== 3'd0) begin
      nerr++; $display("FAIL lw_count: got %0d/st%0d want 2/st0", bus.inst_count, bus.state);
    end
  endtask

  task automatic test_beq();
    logic [19:0] ex [3];
    bus.op = 6'b000100; bus.funct = 6'h2A; bus.mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      ex = '{f_rdy, dec, pk(z[0],2'b01,0,0,0,1,2'b00,3'b110,0,0,0,1,0,3'd2)};
      bus.zero = z[0];
      for (int i = 0; i < 3; i++) begin
        #3; ncmp++;
        if (got1() !== ex[i]) begin
          nerr++; $display("FAIL beq_z%0d c%0d: got %h want %h", z, i, got1(), ex[i]);
        end
        @(posedge clk); #1;
      end
    end
    bus.zero = 1'b0;
    ncmp++;
    if (bus.inst_count !== 4'd4 || bus.state !== 3'd0) begin
      nerr++; $display("FAIL beq_count: got %0d/st%0d want 4/st0", bus.inst_count, bus.state);
    end
  endtask

  task automatic test_sw_addi();
    logic [19:0] ex [11];
    logic        rdy [11];
    logic [5:0]  opv [11];
    ex  = '{f_rdy, dec, ex_i, mem_sw, mem_sw_rt, f_stl, f_stl, f_rdy, dec, ex_i, wb_i};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    opv = '{6'b101011, 6'b101011, 6'b101011, 6'b101011, 6'b101011,
            6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b001000};
    for (int i = 0; i < 11; i++) begin
      bus.op = opv[i]; bus.mem_ready = rdy[i];
      #3; ncmp++;
      if (got1() !== ex[i]) begin
        nerr++; $display("FAIL sw_addi c%0d: got %h want %h", i, got1(), ex[i]);
      end
      @(posedge clk); #1;
    end
    ncmp++;
    if (bus.inst_count !== 4'd6) begin
      nerr++; $display("FAIL sw_addi_count: got %0d want 6", bus.inst_count);
    end
  endtask

  task automatic test_rtype_alu();
    logic [5:0]  fn  [4];
    logic [2:0]  alu [4];
    logic [19:0] ex  [4];
    fn  = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    alu = '{3'b110, 3'b000, 3'b001, 3'b111};
    bus.op = 6'b000000; bus.mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.funct = fn[k];
      ex = '{f_rdy, dec, pk(0,2'b00,0,0,0,1,2'b00,alu[k],0,0,0,0,0,3'd2), wb_r};
      for (int i = 0; i < 4; i++) begin
        #3; ncmp++;
        if (got1() !== ex[i]) begin
          nerr++; $display("FAIL rtype_f%h c%0d: got %h want %h", fn[k], i, got1(), ex[i]);
        end
        @(posedge clk); #1;
      end
    end
    ncmp++;
    if (bus.inst_count !== 4'd10) begin
      nerr++; $display("FAIL rtype_count: got %0d want 10", bus.inst_count);
    end
  endtask

  task automatic test_jump_trap();
    logic [19:0] ex [4];
    logic [5:0]  opv [4];
    ex  = '{f_rdy, dec_j, f_rdy, dec};
    opv = '{6'b000010, 6'b000010, 6'b111111, 6'b111111};
    bus.mem_ready = 1'b1; bus.funct = 6'b100000;
    for (int i = 0; i < 4; i++) begin
      bus.op = opv[i];
      #3; ncmp++;
      if (got1() !== ex[i]) begin
        nerr++; $display("FAIL jump_trap c%0d: got %h want %h", i, got1(), ex[i]);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      #3; ncmp++;
      if (got1() !== trap_v) begin
        nerr++; $display("FAIL trap_hold c%0d: got %h want %h", i, got1(), trap_v);
      end
      @(posedge clk); #1;
    end
    ncmp++;
    if (bus.inst_count !== 4'd11) begin
      nerr++; $display("FAIL trap_count: got %0d want 11", bus.inst_count);
    end
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    #1; ncmp++;
    if (bus.trap !== 1'b0 || bus.state !== 3'd0 || bus.inst_count !== 4'd0) begin
      nerr++; $display("FAIL trap_reset: got trap%0d st%0d cnt%0d want trap0 st0 cnt0",
                       bus.trap, bus.state, bus.inst_count);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #2; ncmp++;
    if (got1() !== f_stl) begin
      nerr++; $display("FAIL trap_release: got %h want %h", got1(), f_stl);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_funct();
    logic [19:0] ex1 [3];
    logic [19:0] ex2 [3];
    ex1 = '{f_rdy, dec, trap_v};
    ex2 = '{f_rdy, dec_ret, f_rdy};
    bus.op = 6'b000000; bus.funct = 6'b111111; bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3; ncmp++;
      if (got1() !== ex1[i]) begin
        nerr++; $display("FAIL illegal_trap c%0d: got %h want %h", i, got1(), ex1[i]);
      end
      ncmp++;
      if (got2() !== ex2[i]) begin
        nerr++; $display("FAIL illegal_nop c%0d: got %h want %h", i, got2(), ex2[i]);
      end
      @(posedge clk); #1;
    end
    ncmp++;
    if (bus2.inst_count !== 4'd1 || bus.inst_count !== 4'd0) begin
      nerr++; $display("FAIL illegal_count: got nop%0d trap%0d want nop1 trap0",
                       bus2.inst_count, bus.inst_count);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_sw();
    logic [19:0] ex [6];
    logic [5:0]  opv [6];
    logic        rdy [6];
    ex  = '{f_rdy, dec_j, f_rdy, dec, ex_i, mem_sw};
    opv = '{6'b000010, 6'b000010, 6'b101011, 6'b101011, 6'b101011, 6'b101011};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      bus.op = opv[i]; bus.mem_ready = rdy[i];
      #3; ncmp++;
      if (got1() !== ex[i]) begin
        nerr++; $display("FAIL mid_sw c%0d: got %h want %h", i, got1(), ex[i]);
      end
      if (i < 5) begin
        @(posedge clk); #1;
      end
    end
    ncmp++;
    if (bus.inst_count !== 4'd1) begin
      nerr++; $display("FAIL mid_sw_precount: got %0d want 1", bus.inst_count);
    end
    reset = 1'b0;
    #1; ncmp++;
    if ({bus.mem_we, bus.retire, bus.state, bus.inst_count} !== 9'd0) begin
      nerr++; $display("FAIL mid_sw_abort: got we%0d rt%0d st%0d cnt%0d want all 0",
                       bus.mem_we, bus.retire, bus.state, bus.inst_count);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #2; ncmp++;
    if (got1() !== f_stl) begin
      nerr++; $display("FAIL mid_sw_release: got %h want %h", got1(), f_stl);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    do_reset();
    bus.op = 6'b000010; bus.mem_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1; ncmp++;
    if (bus.inst_count !== 4'd15) begin
      nerr++; $display("FAIL wrap_full: got %0d want 15", bus.inst_count);
    end
    repeat (2) @(posedge clk);
    #1; ncmp++;
    if (bus.inst_count !== 4'd0) begin
      nerr++; $display("FAIL wrap_zero: got %0d want 0", bus.inst_count);
    end
  endtask

  initial begin
    f_rdy     = pk(1,2'b00,1,1,0,0,2'b01,3'b010,0,0,0,0,0,3'd0);
    f_stl     = pk(0,2'b00,0,1,0,0,2'b01,3'b010,0,0,0,0,0,3'd0);
    dec       = pk(0,2'b00,0,0,0,0,2'b11,3'b010,0,0,0,0,0,3'd1);
    dec_j     = pk(1,2'b10,0,0,0,0,2'b11,3'b010,0,0,0,1,0,3'd1);
    dec_ret   = pk(0,2'b00,0,0,0,0,2'b11,3'b010,0,0,0,1,0,3'd1);
    ex_i      = pk(0,2'b00,0,0,0,1,2'b10,3'b010,0,0,0,0,0,3'd2);
    mem_lw    = pk(0,2'b00,0,1,0,0,2'b00,3'b000,0,0,0,0,0,3'd3);
    mem_sw    = pk(0,2'b00,0,0,1,0,2'b00,3'b000,0,0,0,0,0,3'd3);
    mem_sw_rt = pk(0,2'b00,0,0,1,0,2'b00,3'b000,0,0,0,1,0,3'd3);
    wb_r      = pk(0,2'b00,0,0,0,0,2'b00,3'b000,1,1,0,1,0,3'd4);
    wb_lw     = pk(0,2'b00,0,0,0,0,2'b00,3'b000,1,0,1,1,0,3'd4);
    wb_i      = pk(0,2'b00,0,0,0,0,2'b00,3'b000,1,0,0,1,0,3'd4);
    trap_v    = pk(0,2'b00,0,0,0,0,2'b00,3'b000,0,0,0,0,1,3'd7);

    test_reset();
    test_add();
    test_lw();
    test_beq();
    test_sw_addi();
    test_rtype_alu();
    test_jump_trap();
    test_illegal_funct();
    test_reset_mid_sw();
    test_wrap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control unit that sequences the MIPS-subset CPU datapath (PC, IR, register file, ALU, shared instruction/data memory) through FETCH/DECODE/EXEC/MEM/WB states. Decodes op/funct from the IR and drives every datapath enable and mux select. Stalls on a memory ready handshake and counts retired instructions. Halts in TRAP on an illegal encoding.

Parameters:
CNT_W, 32, width of retired-instruction counter
TRAP_ON_ILLEGAL, 1, 1 = illegal op/funct enters TRAP; 0 = treat as NOP, return to FETCH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
op  input  6  IR[31:26], stable from the cycle after ir_we
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, combinational from current ALU inputs
mem_ready  input  1  memory completed current read/write this cycle
pc_we  output  1  PC load enable
pc_src  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
ir_we  output  1  IR load enable
mem_re  output  1  memory read request
mem_we  output  1  memory write request
alu_src_a  output  1  0 PC, 1 register A
alu_src_b  output  2  00 register B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
reg_we  output  1  register file write enable
reg_dst  output  1  1 rd, 0 rt
mem_to_reg  output  1  1 memory data, 0 ALUOut
retire  output  1  one-cycle pulse when an instruction completes
trap  output  1  high while in TRAP
state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7
inst_count  output  CNT_W  retired instructions

Behaviour:
- Supported: R-type op 000000 (funct add 100000, sub 100010, and 100100, or 100101, slt 101010); lw 100011; sw 101011; addi 001000; beq 000100; j 000010.
- Reset low (async): state=FETCH, inst_count=0; all enables, retire and trap forced 0 while reset=0. Outputs are combinational from state/op/funct/zero/mem_ready. Unlisted outputs default to 0.
- FETCH: mem_re=1, alu_src_a=0, alu_src_b=01, alu_op=ADD. When mem_ready=1: ir_we=1, pc_we=1, pc_src=00, go to DECODE. Otherwise hold with no writes; the stall is unbounded.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD, precomputing the branch target into ALUOut.
  - j: pc_we=1, pc_src=10, retire=1, go to FETCH.
  - Any other legal op/funct: go to EXEC.
  - Illegal op or R-type funct: TRAP if TRAP_ON_ILLEGAL, else retire=1 and go to FETCH.
- EXEC:
  - R-type: alu_src_a=1, alu_src_b=00, alu_op per funct, go to WB.
  - lw/sw: alu_src_a=1, alu_src_b=10, ADD, go to MEM.
  - addi: same ALU setting as lw/sw, go to WB.
  - beq: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_we=zero, retire=1, go to FETCH.
- MEM: lw drives mem_re=1, sw drives mem_we=1, both held until mem_ready=1.
  - lw with ready: go to WB.
  - sw with ready: retire=1, go to FETCH.
  - mem_re/mem_we stay asserted every stall cycle.
- WB: reg_we=1, retire=1, go to FETCH.
  - reg_dst=1 for R-type, 0 otherwise.
  - mem_to_reg=1 for lw, 0 otherwise.
- TRAP: trap=1, all enables 0. Only reset exits TRAP.
- Cycle counts with zero wait states: j=2, beq=3, R-type/addi/sw=4, lw=5. Each wait cycle adds 1.
- inst_count increments on the clock edge where retire=1 and wraps at 2^CNT_W-1 to 0. retire and ir_we are never high in the same cycle.
- Reset asserted mid-instruction aborts it immediately: no retire, count cleared, resume at FETCH after release.
- Unused state encodings (5, 6) go to FETCH next cycle with all enables 0.

Test Plan:
- Reset then add (op 000000, funct 100000), mem_ready tied 1 -> states 0,1,2,4,0; reg_we=1 and reg_dst=1 in WB; retire in cycle 4; inst_count=1.
- lw with mem_ready low 3 cycles in MEM -> mem_re held 4 cycles; WB has mem_to_reg=1, reg_dst=0; 8 cycles total; inst_count increments by 1.
- beq: zero=1 gives pc_we=1 and pc_src=01 in EXEC; zero=0 gives pc_we=0; both retire after 3 cycles.
- j then op=111111 -> j takes 2 cycles with pc_src=10; illegal op gives trap=1 and state=7, held 20 cycles; reset releases to FETCH with inst_count=0.
- Reset asserted in MEM of a sw with mem_ready=0 -> mem_we drops asynchronously, no retire, state=0 after release.
- Force inst_count to all-ones (CNT_W=4 build: 15 instructions retired), retire one more -> inst_count=0.
